// File: rtl/inst_encoder.sv
// Immediate encoder: merges a formatted immediate into an instruction template, 2-deep output FIFO.
// Define INST_ENC_RANGE_CHECK_EN to enable immediate range checking (out_err, err_cnt).
module inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        FMT_I  = 3'b000,
        FMT_S  = 3'b001,
        FMT_U  = 3'b010,
        FMT_J  = 3'b011,
        FMT_B  = 3'b100,
        FMT_LU = 3'b101
    } fmt_e;

    logic [31:0] enc_inst;
    logic        enc_err;

    // Every format overwrites inst[31:25], so those template bits never reach the output.
    logic base_unused;
    assign base_unused = ^in_base[31:25];

    always_comb begin
        enc_inst = {in_imm[11:0], in_base[19:0]};
        case (fmt_e'(in_fmt))
            FMT_S: enc_inst = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
            FMT_U: enc_inst = {in_imm[31:12], in_base[11:0]};
            FMT_J: enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_base[11:0]};
            FMT_B: enc_inst = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1], in_imm[11],
                               in_base[6:0]};
            default: enc_inst = {in_imm[11:0], in_base[19:0]};
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    logic sx11, sx12, sx20;
    assign sx11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign sx12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign sx20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        enc_err = ~sx11;
        case (fmt_e'(in_fmt))
            FMT_U:   enc_err = |in_imm[11:0];
            FMT_LU:  enc_err = |in_imm[31:12];
            FMT_J:   enc_err = in_imm[0] | ~sx20;
            FMT_B:   enc_err = in_imm[0] | ~sx12;
            default: enc_err = ~sx11;
        endcase
    end
`else
    assign enc_err = 1'b0;
`endif

    logic [31:0] mem_inst_q [2];
    logic [31:0] mem_inst_d [2];
    logic        mem_err_q  [2];
    logic        mem_err_d  [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        push, pop;

    // Ready depends on occupancy only, never on out_ready.
    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_inst  = out_valid ? mem_inst_q[rd_ptr_q] : 32'd0;
    assign out_err   = out_valid & mem_err_q[rd_ptr_q];
    assign err_cnt   = err_cnt_q;

    always_comb begin
        mem_inst_d = mem_inst_q;
        mem_err_d  = mem_err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_cnt_d  = err_cnt_q;
        if (push) begin
            mem_inst_d[wr_ptr_q] = enc_inst;
            mem_err_d[wr_ptr_q]  = enc_err;
            wr_ptr_d             = ~wr_ptr_q;
`ifdef INST_ENC_RANGE_CHECK_EN
            if (enc_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_inst_q <= '{default: 32'd0};
            mem_err_q  <= '{default: 1'b0};
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            mem_inst_q <= mem_inst_d;
            mem_err_q  <= mem_err_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder: queue-based reference model plus directed literal cases.
module tb_inst_encoder;

`ifdef INST_ENC_RANGE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = 3'd0;
    logic [31:0] in_imm = 32'd0;
    logic [31:0] in_base = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_cnt;

    int vectors = 0;
    int fails   = 0;
    bit done    = 1'b0;

    inst_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] inst; logic err; } ent_t;
    ent_t mq[$];
    int   mcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: field placement by masks and shifts, error by numeric range.
    function automatic ent_t model(input logic [2:0] f, input logic [31:0] b, input logic [31:0] i);
        ent_t e;
        int   s;
        s = int'(i);
        case (f)
            3'd1: begin
                e.inst = (b & 32'h01FFF07F) | (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
                e.err  = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                e.inst = (b & 32'h00000FFF) | (i & 32'hFFFFF000);
                e.err  = (i % 4096) != 0;
            end
            3'd3: begin
                e.inst = (b & 32'h00000FFF) | (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                       | (((i >> 11) & 1) << 20) | (i & 32'h000FF000);
                e.err  = (i[0] == 1'b1) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
            end
            3'd4: begin
                e.inst = (b & 32'h01FFF07F) | (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25)
                       | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7);
                e.err  = (i[0] == 1'b1) || (s < -4096) || (s > 4095);
            end
            3'd5: begin
                e.inst = (b & 32'h000FFFFF) | (i << 20);
                e.err  = i > 32'd4095;
            end
            default: begin
                e.inst = (b & 32'h000FFFFF) | (i << 20);
                e.err  = (s < -2048) || (s > 2047);
            end
        endcase
        if (!CHK_EN) e.err = 1'b0;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            bit   do_pop, do_push;
            ent_t e;
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = in_valid && (mq.size() < 2);
            e = model(in_fmt, in_base, in_imm);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(e);
                if (e.err && mcnt < 255) mcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            chk("out_inst", out_inst, (mq.size() != 0) ? mq[0].inst : 32'd0);
            chk("out_err", {31'd0, out_err}, {31'd0, (mq.size() != 0) ? mq[0].err : 1'b0});
            chk("err_cnt", {24'd0, err_cnt}, mcnt);
        end
    end

    // Holds the request until accepted; entered and left at posedge+1.
    task automatic send(input logic [2:0] f, input logic [31:0] b, input logic [31:0] i);
        bit rdy;
        in_valid = 1'b1; in_fmt = f; in_base = b; in_imm = i;
        for (int k = 0; k < 50; k++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic directed(input string nm, input logic [2:0] f, input logic [31:0] b,
                            input logic [31:0] i, input logic [31:0] e_inst, input logic e_err);
        in_valid = 1'b1; in_fmt = f; in_base = b; in_imm = i;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_inst"}, out_inst, e_inst);
        chk({nm, "_err"}, {31'd0, out_err}, {31'd0, e_err});
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_imm();
        logic [31:0] bnd [12];
        bnd = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFF, 32'h1000,
                32'hFFE, 32'hFFFFF000, 32'hFFFFEFFF, 32'hFFFFE, 32'h100000, 32'hFFF00000};
        case ($urandom % 5)
            0:       return $urandom_range(0, 8191) - 32'd4096;
            1:       return $urandom & 32'hFFFFF000;
            2:       return $urandom_range(0, 4194303) - 32'd2097152;
            3:       return bnd[$urandom % 12];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;

        directed("i_addi", 3'b000, 32'h00000013, 32'h00000005, 32'h00500013, 1'b0);
        directed("s_sw", 3'b001, 32'h00002023, 32'hFFFFFFFC, 32'hFE002E23, 1'b0);
        directed("j_jal", 3'b011, 32'h0000006F, 32'h00000800, 32'h0010006F, 1'b0);
        directed("b_odd", 3'b100, 32'h00000063, 32'h00000003, 32'h00000163, CHK_EN);
        directed("i_ovf", 3'b000, 32'h00000013, 32'h00000800, 32'h80000013, CHK_EN);
        chk("errcnt_two", {24'd0, err_cnt}, CHK_EN ? 32'd2 : 32'd0);

        // Backpressure: two accepted, third held until the consumer drains.
        out_ready = 1'b0;
        fork
            begin
                send(3'b010, 32'h00000037, 32'h12345000);
                send(3'b101, 32'h00000013, 32'h00000ABC);
                send(3'b000, 32'h00000093, 32'hFFFFFFFF);
            end
            begin
                repeat (2) @(posedge clk);
                #2 chk("full_ready", {31'd0, in_ready}, 32'd0);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1 chk("drained", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with two words buffered.
        out_ready = 1'b0;
        send(3'b000, 32'h00000013, 32'h00000001);
        send(3'b000, 32'h00000013, 32'h00000002);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_inst", out_inst, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("arst_stale", {31'd0, out_valid}, 32'd0);

        // Sustained one-per-cycle traffic of erroneous requests to saturate the counter.
        for (int k = 0; k < 270; k++) send(3'b100, 32'h00000063, 32'h00000001);
        @(posedge clk); #1;
        chk("errcnt_sat", {24'd0, err_cnt}, CHK_EN ? 32'd255 : 32'd0);

        // Randomized traffic.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom % 3) != 0;
            in_fmt    = 3'($urandom_range(0, 7));
            in_base   = $urandom;
            in_imm    = rnd_imm();
            out_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  request valid.
REQ-004 SHALL have port: in_ready  output  1  request accepted when in_valid&in_ready at clk edge.
REQ-005 SHALL have port: in_fmt  input  3  immediate format: 000 I, 001 S, 010 U, 011 J, 100 B, 101 I-unsigned (LU), 110/111 treated as I.
REQ-006 SHALL have port: in_imm  input  32  immediate value, byte offset for B/J.
REQ-007 SHALL have port: in_base  input  32  instruction template; supplies every bit not owned by the immediate field.
REQ-008 SHALL have port: out_valid  output  1  encoded word valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts when out_valid&out_ready.
REQ-010 SHALL have port: out_inst  output  32  encoded instruction.
REQ-011 SHALL have port: out_err  output  1  immediate not representable in the selected format.
REQ-012 SHALL have port: err_cnt  output  8  saturating count of accepted requests with error.

Function
REQ-013 SHALL place immediate bits by format; all other bits equal in_base: I/LU inst[31:20]=imm[11:0]; S inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; U inst[31:12]=imm[31:12]; J inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]; B inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
REQ-014 SHALL flag error when: I/S imm[31:11] not all equal; LU imm[31:12]!=0; U imm[11:0]!=0; J imm[0]=1 or imm[31:20] not all equal; B imm[0]=1 or imm[31:12] not all equal.
REQ-015 SHALL still emit the truncated encoding when error is flagged; the error travels with its word.
REQ-016 SHALL buffer results in a 2-entry FIFO (word + err); in_ready = (occupancy < 2), combinational from state only.
REQ-017 SHALL present an accepted request on out_* in the cycle after acceptance when the FIFO was empty (latency 1).
REQ-018 SHALL hold out_inst/out_err stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve order.
REQ-020 SHALL sustain one request per cycle when out_ready is held 1.
REQ-021 SHALL increment err_cnt on each accepted erroneous request, saturating at 255, never wrapping.
REQ-022 SHALL drive out_inst=0, out_err=0 whenever out_valid=0.

Reset
REQ-023 SHALL, while rst=1, immediately force FIFO empty, out_valid=0, out_inst=0, out_err=0, err_cnt=0; in_ready=1.
REQ-024 SHALL discard buffered entries when rst asserts mid-operation; no stale word appears after release.
REQ-025 SHALL accept a request on the first clk edge with rst=0.

Configuration
REQ-026 SHALL, with INST_ENC_RANGE_CHECK_EN defined, implement REQ-014 and REQ-021.
REQ-027 SHALL, without INST_ENC_RANGE_CHECK_EN, tie out_err and err_cnt to 0 with no check logic; encoding, handshake and latency unchanged.

Verification
REQ-028 SHALL cover: fmt=000, base=0x00000013, imm=0x00000005 -> next cycle out_inst=0x00500013, out_err=0.
REQ-029 SHALL cover: fmt=001, base=0x00002023, imm=0xFFFFFFFC -> out_inst=0xFE002E23, out_err=0.
REQ-030 SHALL cover: fmt=011, base=0x0000006F, imm=0x00000800 -> out_inst=0x0010006F, out_err=0.
REQ-031 SHALL cover (macro on): fmt=100 imm=0x00000003, then fmt=000 imm=0x00000800 -> both out_err=1, err_cnt=2; macro off -> out_err=0, err_cnt=0.
REQ-032 SHALL cover: out_ready=0, three back-to-back requests -> in_ready=0 after two accepts, third held; release out_ready -> three words in order, none lost.
REQ-033 SHALL cover: two words buffered, rst pulsed asynchronously between edges -> out_valid=0 immediately, no buffered word emitted after release.
